complex_frame_accum: RTL and testbench
======================================

Name: complex_frame_accum

Overview:
- Sits directly downstream of the complex multiplier and consumes its z_real/z_imag product stream.
- Sums FRAME_LEN accepted products into one complex total at full precision, giving a complex dot product or correlation over a frame.
- Presents the total through a single-entry output register with a valid/ready handshake.
- Back-pressures the upstream stage while a result is pending.

Parameters:
- IN_W, 16, width of signed input real/imag (matches multiplier output).
- FRAME_LEN, 4, number of products per frame; legal range 2..1024.
- ACC_W, IN_W+$clog2(FRAME_LEN), output/accumulator width; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous frame abort; zeroes accumulator and sample count.
- in_valid  in  1  product present (driven from multiplier data_valid timing).
- in_ready  out  1  block can accept a product this cycle.
- in_real  in  IN_W  signed real product.
- in_imag  in  IN_W  signed imaginary product.
- out_valid  out  1  frame total held in output register.
- out_ready  in  1  downstream accepts total.
- out_real  out  ACC_W  signed frame sum, real.
- out_imag  out  ACC_W  signed frame sum, imaginary.
- sample_cnt  out  $clog2(FRAME_LEN)  products accepted in the current frame.

Behaviour:
- Reset (rst_n low, async):
  - acc_real, acc_imag, sample_cnt = 0.
  - out_valid = 0; out_real, out_imag = 0.
  - State = ACC.
- Accept condition: in_valid && in_ready.
- in_ready = !(out_valid && !out_ready). This is combinational, so a pending result drained in the same cycle still permits acceptance.
- Inputs are sign-extended to ACC_W before adding. With FRAME_LEN ≤ 2^(ACC_W-IN_W) no overflow is possible, so there is no saturation or wrap.
- State ACC, non-final accept (sample_cnt < FRAME_LEN-1):
  - acc += sign-extended input.
  - sample_cnt += 1.
- State ACC, final accept (sample_cnt == FRAME_LEN-1):
  - out_real/out_imag <= acc + input, computed in the same cycle.
  - out_valid <= 1.
  - acc <= 0 and sample_cnt <= 0; the next frame may begin the following cycle.
  - State -> HOLD.
- Latency: out_valid rises one clock after the final product is accepted.
- State HOLD:
  - out_valid stays high and out data stays stable until out_valid && out_ready.
  - On handshake, out_valid <= 0 and state -> ACC.
  - In the handshake cycle in_ready is high, so a product arriving in that cycle is accepted into the new frame.
- Back-pressure: if out_ready is low in HOLD, in_ready is low and upstream products are not consumed. The upstream must hold them; the multiplier pulse stream is expected to respect in_ready.
- in_valid low: no change to acc or sample_cnt; gaps between products of any length are allowed.
- clear (highest priority, any state):
  - acc and sample_cnt go to 0.
  - A product presented in the same cycle is discarded.
  - A pending output (out_valid) is NOT affected and still completes its handshake.
- Reset mid-frame or mid-HOLD: everything returns to reset values immediately; a partial sum or pending result is lost.
- Output data is registered only. There is no combinational path from in_* to out_*.

Decomposition:
- Shared package complex_pkg holds:
  - IN_W default 16 and operand width 8.
  - ACC_W derivation function.
  - State enum ACC/HOLD.
  - Complex struct typedef {real, imag} at each width.
- One sub-module, complex_acc_lane: a single signed accumulator with add/clear/load-out controls.
  - Instantiated twice (real, imag) under the shared control FSM and counter in complex_frame_accum.

Test Plan (FRAME_LEN=4, ACC_W=18, out_ready=1 unless stated):
- Stream products -5+10i, -20+40i, -16+22i, -3+4i, each valid one cycle with 2-cycle gaps -> single out_valid pulse one cycle after the 4th accept with out_real=-44, out_imag=76; sample_cnt back to 0.
- Back-to-back frames: the above four, then -9+38i ×4 on consecutive cycles -> second total -36+152i; in_ready never drops.
- Hold out_ready=0 after first frame completes, present -9+38i -> in_ready=0, sample not consumed, out_real/out_imag stable at -44/76. Raise out_ready -> handshake; the sample is accepted in that cycle and sample_cnt=1 next cycle.
- Extremes: four products of -32768 (real) and 32767 (imag) -> out_real=-131072, out_imag=131068, no wrap.
- Assert clear after two products (-5+10i, -20+40i) together with in_valid on a third -> sample_cnt=0 and the third is dropped; the next four products -3+4i give total -12+16i.
- Pull rst_n low asynchronously mid-frame and during HOLD -> outputs and counter go to 0 without a clock edge; the first frame after release sums correctly.

Source files
------------

// File: rtl/complex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : complex_pkg
//  Description : Shared widths, accumulator-width derivation, control state
//                enum and complex sample types for the frame accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
package complex_pkg;

    localparam int IN_W_DEF      = 16;
    localparam int OP_W          = 8;
    localparam int FRAME_LEN_DEF = 4;

    // Width needed to sum frame_len samples of in_w bits without overflow
    function automatic int acc_width(input int in_w, input int frame_len);
        return in_w + $clog2(frame_len);
    endfunction

    localparam int ACC_W_DEF = acc_width(IN_W_DEF, FRAME_LEN_DEF);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } acc_state_t;

    // Operand (pre-multiplier) complex sample
    typedef struct packed {
        logic signed [OP_W-1:0] re;
        logic signed [OP_W-1:0] im;
    } complex_op_t;

    // Product (multiplier output / accumulator input) complex sample
    typedef struct packed {
        logic signed [IN_W_DEF-1:0] re;
        logic signed [IN_W_DEF-1:0] im;
    } complex_in_t;

    // Frame total at default accumulator width
    typedef struct packed {
        logic signed [ACC_W_DEF-1:0] re;
        logic signed [ACC_W_DEF-1:0] im;
    } complex_acc_t;

endpackage : complex_pkg
`default_nettype wire

// File: rtl/complex_acc_lane.sv
`default_nettype none
// ============================================================================
//  Module      : complex_acc_lane
//  Description : One signed accumulator lane. Adds sign-extended samples,
//                and on the final sample loads acc+sample into its output
//                register while zeroing the running sum.
//  Revision    : 1.0  initial release
// ============================================================================
module complex_acc_lane
    import complex_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int ACC_W = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    add_en,
    input  logic                    final_en,
    input  logic signed [IN_W-1:0]  in_data,
    output logic signed [ACC_W-1:0] out_data
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_sum;

    assign w_ext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    assign w_sum = r_acc + w_ext;

    // Running sum and frame-total register; clear wins over any sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            out_data <= '0;
        end else if (clear) begin
            r_acc    <= '0;
        end else if (final_en) begin
            out_data <= w_sum;
            r_acc    <= '0;
        end else if (add_en) begin
            r_acc    <= w_sum;
        end
    end

endmodule : complex_acc_lane
`default_nettype wire

// File: rtl/complex_frame_accum.sv
`default_nettype none
// ============================================================================
//  Module      : complex_frame_accum
//  Description : Sums FRAME_LEN complex products into one full-precision
//                total, presented via a single-entry valid/ready register
//                that back-pressures the upstream while a result is pending.
//  Revision    : 1.0  initial release
// ============================================================================
module complex_frame_accum
    import complex_pkg::*;
#(
    parameter  int IN_W      = IN_W_DEF,
    parameter  int FRAME_LEN = FRAME_LEN_DEF,
    localparam int ACC_W     = acc_width(IN_W, FRAME_LEN),
    localparam int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_real,
    input  logic signed [IN_W-1:0]  in_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_real,
    output logic signed [ACC_W-1:0] out_imag,
    output logic [CNT_W-1:0]        sample_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    acc_state_t r_state;
    logic       w_accept;
    logic       w_last;
    logic       w_add;
    logic       w_final;
    logic       w_drain;

    // A result drained this cycle frees the register, so acceptance is allowed
    assign in_ready = !(out_valid && !out_ready);
    assign w_accept = in_valid && in_ready && !clear;
    assign w_last   = (sample_cnt == LAST_CNT);
    assign w_final  = w_accept && w_last;
    assign w_add    = w_accept && !w_last;
    assign w_drain  = out_valid && out_ready;

    // Control FSM: sample counter, output-valid flag and ACC/HOLD state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ACC;
            out_valid  <= 1'b0;
            sample_cnt <= '0;
        end else begin
            if (clear || w_final) begin
                sample_cnt <= '0;
            end else if (w_add) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_ACC: begin
                    if (w_final) begin
                        out_valid <= 1'b1;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_final) begin
                        out_valid <= 1'b1;
                    end else if (w_drain) begin
                        out_valid <= 1'b0;
                        r_state   <= ST_ACC;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    complex_acc_lane #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_lane_real (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .add_en   (w_add),
        .final_en (w_final),
        .in_data  (in_real),
        .out_data (out_real)
    );

    complex_acc_lane #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_lane_imag (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .add_en   (w_add),
        .final_en (w_final),
        .in_data  (in_imag),
        .out_data (out_imag)
    );

endmodule : complex_frame_accum
`default_nettype wire

// File: tb/tb_complex_frame_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_complex_frame_accum
//  Description : Self-checking bench for complex_frame_accum with directed
//                scenarios and randomized traffic against a frame-level
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_complex_frame_accum;

    localparam int IN_W      = 16;
    localparam int FRAME_LEN = 4;
    localparam int ACC_W     = 18;
    localparam int CNT_W     = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    clear;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_real;
    logic signed [IN_W-1:0]  in_imag;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_real;
    logic signed [ACC_W-1:0] out_imag;
    logic [CNT_W-1:0]        sample_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: products of the current frame, and the pending total
    int     m_frame_re[$];
    int     m_frame_im[$];
    bit     m_out_valid;
    longint m_out_re;
    longint m_out_im;

    always #5 clk = ~clk;

    complex_frame_accum #(
        .IN_W      (IN_W),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .sample_cnt (sample_cnt)
    );

    task automatic check(input string tag, input longint observed, input longint expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_frame_re.delete();
        m_frame_im.delete();
        m_out_valid = 1'b0;
        m_out_re    = 0;
        m_out_im    = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, longint'(out_valid), longint'(m_out_valid));
        check({tag, ".out_real"},  longint'(out_real),  m_out_re);
        check({tag, ".out_imag"},  longint'(out_imag),  m_out_im);
        check({tag, ".cnt"},       longint'(sample_cnt), longint'(m_frame_re.size()));
    endtask

    // One clock cycle: entered and left at posedge+1
    task automatic drive(input bit v, input int re, input int im, input bit ordy, input bit clr);
        bit exp_ready;
        bit acc;
        bit hs;
        longint s_re;
        longint s_im;
        in_valid  = v;
        in_real   = IN_W'(re);
        in_imag   = IN_W'(im);
        out_ready = ordy;
        clear     = clr;
        #1;
        exp_ready = !(m_out_valid && !ordy);
        check("in_ready", longint'(in_ready), longint'(exp_ready));
        @(posedge clk);
        acc = v && exp_ready && !clr;
        hs  = m_out_valid && ordy;
        if (hs) m_out_valid = 1'b0;
        if (clr) begin
            m_frame_re.delete();
            m_frame_im.delete();
        end else if (acc) begin
            m_frame_re.push_back(re);
            m_frame_im.push_back(im);
            if (m_frame_re.size() == FRAME_LEN) begin
                s_re = 0;
                s_im = 0;
                foreach (m_frame_re[k]) begin
                    s_re += m_frame_re[k];
                    s_im += m_frame_im[k];
                end
                m_out_re    = s_re;
                m_out_im    = s_im;
                m_out_valid = 1'b1;
                m_frame_re.delete();
                m_frame_im.delete();
            end
        end
        #1;
        check_outputs("cyc");
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, ordy, 1'b0);
    endtask

    // Asynchronous reset pulse applied between clock edges
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int rp_re[4];
        int rp_im[4];
        rp_re = '{-5, -20, -16, -3};
        rp_im = '{10, 40, 22, 4};

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_real = '0; in_imag = '0;
        model_reset();
        #12;
        check_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame with 2-cycle gaps
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rp_re[i], rp_im[i], 1'b1, 1'b0);
            if (i < 3) idle(2, 1'b1);
        end
        check("gap.real", longint'(out_real), -44);
        check("gap.imag", longint'(out_imag), 76);
        check("gap.valid", longint'(out_valid), 1);
        idle(1, 1'b1);

        // Back-to-back frames
        for (int i = 0; i < 4; i++) drive(1'b1, rp_re[i], rp_im[i], 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, -9, 38, 1'b1, 1'b0);
        check("b2b.real", longint'(out_real), -36);
        check("b2b.imag", longint'(out_imag), 152);
        idle(1, 1'b1);

        // Back-pressure while a total is pending
        for (int i = 0; i < 4; i++) drive(1'b1, rp_re[i], rp_im[i], 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, -9, 38, 1'b0, 1'b0);
        check("bp.real", longint'(out_real), -44);
        check("bp.imag", longint'(out_imag), 76);
        drive(1'b1, -9, 38, 1'b1, 1'b0);
        check("bp.cnt", longint'(sample_cnt), 1);
        for (int i = 0; i < 3; i++) drive(1'b1, -9, 38, 1'b1, 1'b0);
        idle(1, 1'b1);

        // Extremes
        for (int i = 0; i < 4; i++) drive(1'b1, -32768, 32767, 1'b1, 1'b0);
        check("ext.real", longint'(out_real), -131072);
        check("ext.imag", longint'(out_imag), 131068);
        idle(1, 1'b1);

        // Clear mid-frame with a colliding product
        drive(1'b1, -5, 10, 1'b1, 1'b0);
        drive(1'b1, -20, 40, 1'b1, 1'b0);
        drive(1'b1, -16, 22, 1'b1, 1'b1);
        check("clr.cnt", longint'(sample_cnt), 0);
        for (int i = 0; i < 4; i++) drive(1'b1, -3, 4, 1'b1, 1'b0);
        check("clr.real", longint'(out_real), -12);
        check("clr.imag", longint'(out_imag), 16);
        idle(1, 1'b1);

        // Clear while a total is pending leaves it intact
        for (int i = 0; i < 4; i++) drive(1'b1, rp_re[i], rp_im[i], 1'b1, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        idle(1, 1'b1);

        // Asynchronous reset mid-frame and during HOLD
        drive(1'b1, 100, -100, 1'b1, 1'b0);
        drive(1'b1, 200, -200, 1'b1, 1'b0);
        async_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, rp_re[i], rp_im[i], 1'b0, 1'b0);
        idle(2, 1'b0);
        async_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, rp_re[i], rp_im[i], 1'b1, 1'b0);
        check("post_rst.real", longint'(out_real), -44);
        idle(1, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 60),
                  int'($signed(16'($urandom))),
                  int'($signed(16'($urandom))),
                  ($urandom_range(0, 99) < 70),
                  ($urandom_range(0, 99) < 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_complex_frame_accum
`default_nettype wire
